// File: rtl/wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone B4 arbiter with cycle locking,
// round-robin tie-break and an outstanding-strobe limiter for the owner.
module wb_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,

  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       last;
  logic [3:0] outstanding;

  logic limit;
  logic accept;
  logic ack_dec;
  logic grant_entry;
  logic grant_idx;

  assign limit       = (outstanding == MAX_CNT);
  assign accept      = s_wb_stb_o & ~s_wb_stall_i;
  // A stray ack with nothing in flight is still forwarded but must not underflow.
  assign ack_dec     = s_wb_ack_i & (outstanding != 4'd0);
  assign grant_entry = (state_next != IDLE) && (state_next != state);
  assign grant_idx   = (state_next == GRANT1);

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) state_next = last ? GRANT0 : GRANT1;
        else if (m0_wb_cyc_i)           state_next = GRANT0;
        else if (m1_wb_cyc_i)           state_next = GRANT1;
      end
      GRANT0: begin
        if (!m0_wb_cyc_i) state_next = m1_wb_cyc_i ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (!m1_wb_cyc_i) state_next = m0_wb_cyc_i ? GRANT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = '0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_stall_o = 1'b1;
    unique case (state)
      GRANT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_stb_i & ~limit;
        m0_wb_stall_o = s_wb_stall_i | limit;
        m0_wb_ack_o   = s_wb_ack_i;
      end
      GRANT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_stb_i & ~limit;
        m1_wb_stall_o = s_wb_stall_i | limit;
        m1_wb_ack_o   = s_wb_ack_i;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last        <= 1'b1;
      outstanding <= 4'd0;
    end else begin
      state <= state_next;
      if (grant_entry) begin
        last        <= grant_idx;
        outstanding <= 4'd0;
      end else if (accept && !ack_dec) begin
        outstanding <= outstanding + 4'd1;
      end else if (!accept && ack_dec) begin
        outstanding <= outstanding - 4'd1;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master, one-slave arbiter for the pipelined Wishbone B4 bus in front of the memory's Wishbone interface. It shares the single memory port between two requesters, such as a CPU instruction port (master 0) and a data port (master 1). Ownership is locked for a whole bus cycle (`cyc`), alternates round-robin on contention, and the owner's outstanding requests are counted so every ack reaches the right master.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum number of un-acked strobes the owner may have in flight; must be between 1 and 15.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `m0_wb_adr_i`, `m1_wb_adr_i`  in  32  master address.
- `m0_wb_dat_i`, `m1_wb_dat_i`  in  32  master write data.
- `m0_wb_dat_o`, `m1_wb_dat_o`  out  32  read data; both are driven from `s_wb_dat_i`.
- `m0_wb_we_i`, `m1_wb_we_i`  in  1  write enable.
- `m0_wb_sel_i`, `m1_wb_sel_i`  in  4  byte select.
- `m0_wb_stb_i`, `m1_wb_stb_i`  in  1  strobe.
- `m0_wb_cyc_i`, `m1_wb_cyc_i`  in  1  cycle / bus request.
- `m0_wb_ack_o`, `m1_wb_ack_o`  out  1  ack.
- `m0_wb_stall_o`, `m1_wb_stall_o`  out  1  stall.
- `s_wb_adr_o`, `s_wb_dat_o`, `s_wb_we_o`, `s_wb_sel_o`, `s_wb_stb_o`, `s_wb_cyc_o`  out  32/32/1/4/1/1  slave-side request.
- `s_wb_dat_i`, `s_wb_ack_i`, `s_wb_stall_i`  in  32/1/1  slave-side response.

## Operation
State machine (registered):
- `IDLE`: no owner.
- `GRANT0`: master 0 owns the bus.
- `GRANT1`: master 1 owns the bus.

Other registers:
- `last` (1 bit): the most recently granted master.
- `outstanding` (4 bits): un-acked strobes of the current owner.

Reset state: `IDLE`, `last`=1 (so master 0 wins the first tie), `outstanding`=0.

Transitions:
- `IDLE` → `GRANTx` when only `mx_wb_cyc_i`=1.
- `IDLE`, both `cyc` high → grant the master that is not `last`.
- `GRANTx` holds while `mx_wb_cyc_i`=1.
- `GRANTx`, owner drops `cyc`, other master's `cyc`=1 → go directly to the other master's `GRANT` state (handoff).
- `GRANTx`, owner drops `cyc`, other master idle → `IDLE`.
- On every entry to a `GRANT` state: `last` ← granted index, `outstanding` ← 0.

Forwarding in `GRANTx` (combinational):
- `s_wb_adr_o`, `s_wb_dat_o`, `s_wb_we_o`, `s_wb_sel_o` = owner's request fields.
- `s_wb_cyc_o` = owner's `cyc`.
- `s_wb_stb_o` = owner `stb` & !limit, where limit = (`outstanding` == `MAX_OUTSTANDING`).
- Owner stall = `s_wb_stall_i` | limit.
- Owner ack = `s_wb_ack_i`.
- Non-owner: stall=1, ack=0.

In `IDLE`:
- `s_wb_cyc_o`=0, `s_wb_stb_o`=0.
- Both stall=1, both ack=0.
- Address, data, we and sel are driven 0.

`outstanding` update each cycle:
- +1 on an accepted strobe (`s_wb_stb_o` & !`s_wb_stall_i`).
- −1 on `s_wb_ack_i`.
- Both in the same cycle: unchanged.
- Never wraps. An ack arriving with `outstanding`=0 is forwarded but the counter holds at 0.

Owner drops `cyc` with `outstanding`≠0:
- The cycle is abandoned and `s_wb_cyc_o` falls.
- The counter is cleared on the next grant.
- Late slave acks go to neither master while `IDLE`, or to whichever master owns the bus at that time; this is the Wishbone abort behaviour.

Reset mid-transfer:
- All outputs go to their `IDLE` values immediately (asynchronous).
- The state machine and counters are cleared.

## Timing
- Grant latency: a `cyc` that rises in cycle N with the arbiter in `IDLE` gets a grant from cycle N+1. The master sees stall=1 in cycle N and its first strobe can be accepted in N+1.
- Handoff: the owner's `cyc` low in cycle N → the other master is granted in N+1. There are no `IDLE` cycles in between and no cycle where both masters are granted.
- Forwarding is zero-latency. Owner `stb`, stall and ack pass through combinationally in the same cycle.
- Throughput: one accepted strobe per cycle while the slave does not stall and the limit is not reached.
- Reset values: all slave-side outputs are 0; `m0`/`m1` ack=0; `m0`/`m1` stall=1; `m*_wb_dat_o` = `s_wb_dat_i`.

## Test plan
- Single master 0 reads 3 words back-to-back (adr 0x0, 0x4, 0x8) with the slave acking 1 cycle later → grant one cycle after `cyc`; 3 accepted strobes; `m0_wb_ack_o` pulses 3 times; `m1_wb_ack_o` stays 0; `outstanding` returns to 0.
- Both masters raise `cyc` in the same cycle right after reset → master 0 is granted. When master 0 drops `cyc`, master 1 is granted on the next cycle. On the next tie, master 0 is served first again (round-robin alternates).
- `MAX_OUTSTANDING`=2, slave delays acks by 4 cycles, master 0 strobes continuously → `m0_wb_stall_o`=1 after 2 accepted strobes; `s_wb_stb_o`=0 until the first ack, then 1 again.
- A simultaneous accept and ack cycle → `outstanding` is unchanged. A slave stall held for 3 cycles → the owner sees stall=1 and the strobe is accepted only on the cycle the stall clears.
- Master 1 write with `sel`=0b0011 and data 0xDEADBEEF while master 0 requests → the slave sees master 1's exact `adr`/`dat`/`sel`/`we`; master 0 stays stalled with no ack.
- `rst_i` asserted mid-burst with `outstanding`=2 → the slave `cyc`/`stb` drop in the same cycle, both stalls go to 1, and the state is `IDLE` after reset release.
